// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 memory slave on a flop array, one outstanding burst per direction.
// Optional range checking with SLVERR responses: `define AXI_MEM_SLVERR_EN
module axi_mem_slave #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_BYTES  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic [2:0]              aw_size_i,
    input  logic [1:0]              aw_burst_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ID_WIDTH-1:0]     ar_id_i,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic [2:0]              ar_size_i,
    input  logic [1:0]              ar_burst_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int MEM_BITS   = $clog2(MEM_BYTES);
    localparam int IDX_BITS   = MEM_BITS - OFF_BITS;
    localparam int WORDS      = MEM_BYTES / STRB_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [1:0]            w_burst_q;
    logic                  w_err_q;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [1:0]            r_burst_q;

    logic [ADDR_WIDTH-1:0] w_off, r_off;
    logic [IDX_BITS-1:0]   w_idx, r_idx;
    logic                  w_in_range, r_in_range;
    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  unused_bits;

    // FIXED holds the address; INCR and WRAP both step by one beat.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + BEAT_INC;
    endfunction

    assign w_off = w_addr_q - BASE_ADDR;
    assign r_off = r_addr_q - BASE_ADDR;
    assign w_idx = w_off[MEM_BITS-1:OFF_BITS];
    assign r_idx = r_off[MEM_BITS-1:OFF_BITS];

`ifdef AXI_MEM_SLVERR_EN
    // Addresses below BASE_ADDR wrap to huge offsets and fail this compare too.
    assign w_in_range = (w_off < ADDR_WIDTH'(MEM_BYTES));
    assign r_in_range = (r_off < ADDR_WIDTH'(MEM_BYTES));
`else
    assign w_in_range = 1'b1;
    assign r_in_range = 1'b1;
`endif

    assign unused_bits = ^{w_off[OFF_BITS-1:0], r_off[OFF_BITS-1:0],
                           w_off[ADDR_WIDTH-1:MEM_BITS], r_off[ADDR_WIDTH-1:MEM_BITS],
                           aw_size_i, ar_size_i, w_last_i};

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign w_hs  = w_valid_i && w_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;
    assign r_hs  = r_valid_o && r_ready_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_id_q    <= aw_id_i;
                w_addr_q  <= aw_addr_i;
                w_len_q   <= aw_len_i;
                w_burst_q <= aw_burst_i;
                w_cnt_q   <= '0;
                w_err_q   <= 1'b0;
            end else if (w_hs) begin
                w_addr_q <= next_addr(w_addr_q, w_burst_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
                if (!w_in_range) w_err_q <= 1'b1;
            end
        end
    end

    // Beat count alone ends the burst; w_last_i is not trusted.
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign b_id_o   = w_id_q;
    assign b_resp_o = (b_valid_o && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // Array is intentionally not reset; beats written before a reset survive it.
    always_ff @(posedge clk_i) begin
        if (w_hs && w_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_i[b]) mem[w_idx][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q    <= ar_id_i;
                r_addr_q  <= ar_addr_i;
                r_len_q   <= ar_len_i;
                r_burst_q <= ar_burst_i;
                r_cnt_q   <= '0;
            end else if (r_hs) begin
                r_addr_q <= next_addr(r_addr_q, r_burst_q);
                r_cnt_q  <= r_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                if (r_ready_i && (r_cnt_q == r_len_q)) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data comes straight off the array, so a same-cycle write shows up next cycle.
    assign r_id_o   = r_id_q;
    assign r_last_o = r_valid_o && (r_cnt_q == r_len_q);
    assign r_data_o = (r_valid_o && r_in_range) ? mem[r_idx] : '0;
    assign r_resp_o = (r_valid_o && !r_in_range) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed scoreboard bench for axi_mem_slave (default build).
module tb_axi_mem_slave;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        aw_valid_i, aw_ready_o;
    logic [3:0]  aw_id_i;
    logic [63:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [2:0]  aw_size_i;
    logic [1:0]  aw_burst_i;
    logic        w_valid_i, w_ready_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [3:0]  ar_id_i;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic        r_valid_o, r_ready_i;
    logic [3:0]  r_id_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wd[8];
    logic [3:0]  ws[8];
    int          n_cmp = 0;
    int          n_bad = 0;

    axi_mem_slave dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .aw_burst_i(aw_burst_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .ar_burst_i(ar_burst_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        e.resp = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
        aw_burst_i = burst; aw_size_i = 3'd2;
        while (!aw_ready_o && t < 50) begin step(); t++; end
        if (!aw_ready_o) timeout("aw_hs");
        step();
        aw_valid_i = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
        int t = 0;
        w_valid_i = 1'b1; w_data_i = d; w_strb_i = s; w_last_i = last;
        while (!w_ready_o && t < 50) begin step(); t++; end
        if (!w_ready_o) timeout("w_hs");
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) w_send(wd[i], ws[i], i == int'(len));
        b_ready_i = 1'b1;
        while (!b_valid_o && t < 50) begin step(); t++; end
        if (!b_valid_o) timeout("b_hs");
        check("b_id", 64'(b_id_o), 64'(id));
        check("b_resp", 64'(b_resp_o), 64'h0);
        step();
        b_ready_i = 1'b0;
        check("b_valid_one_cycle", 64'(b_valid_o), 64'h0);
    endtask

    // Odd beats are first held off with r_ready low to check output stability.
    task automatic axi_read(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input bit stall);
        int   t;
        exp_t e;
        logic [31:0] snap_d;
        logic        snap_l;
        ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
        ar_burst_i = burst; ar_size_i = 3'd2;
        t = 0;
        while (!ar_ready_o && t < 50) begin step(); t++; end
        if (!ar_ready_o) timeout("ar_hs");
        step();
        ar_valid_i = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!r_valid_o && t < 50) begin step(); t++; end
            if (!r_valid_o) timeout("r_valid");
            if (stall && (i % 2 == 1)) begin
                r_ready_i = 1'b0;
                snap_d = r_data_o;
                snap_l = r_last_o;
                step();
                check("r_valid_hold", 64'(r_valid_o), 64'h1);
                check("r_data_hold", 64'(r_data_o), 64'(snap_d));
                check("r_last_hold", 64'(r_last_o), 64'(snap_l));
            end
            r_ready_i = 1'b1;
            if (exp_q.size() == 0) timeout("scoreboard_empty");
            else begin
                e = exp_q.pop_front();
                check("r_data", 64'(r_data_o), 64'(e.data));
                check("r_last", 64'(r_last_o), 64'(e.last));
                check("r_resp", 64'(r_resp_o), 64'(e.resp));
                check("r_id", 64'(r_id_o), 64'(id));
            end
            step();
            r_ready_i = 1'b0;
        end
        check("r_valid_done", 64'(r_valid_o), 64'h0);
    endtask

    initial begin
        arst_ni = 1'b0;
        aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
        w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
        r_ready_i = 0;
        step(); step();
        check("rst_aw_ready", 64'(aw_ready_o), 64'h1);
        check("rst_ar_ready", 64'(ar_ready_o), 64'h1);
        check("rst_w_ready", 64'(w_ready_o), 64'h0);
        check("rst_b_valid", 64'(b_valid_o), 64'h0);
        check("rst_r_valid", 64'(r_valid_o), 64'h0);
        check("rst_r_last", 64'(r_last_o), 64'h0);
        check("rst_r_data", 64'(r_data_o), 64'h0);
        arst_ni = 1'b1;
        step();

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'h5, 64'h100, 8'd0, 2'b01);
        push(32'hDEADBEEF, 1'b1);
        axi_read(4'h3, 64'h100, 8'd0, 2'b01, 1'b0);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(4'h1, 64'h200, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) push(32'(i + 1), i == 3);
        axi_read(4'h2, 64'h200, 8'd3, 2'b01, 1'b1);

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        axi_write(4'h6, 64'h40, 8'd0, 2'b01);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        axi_write(4'h7, 64'h40, 8'd0, 2'b01);
        push(32'h11BB33DD, 1'b1);
        axi_read(4'h8, 64'h40, 8'd0, 2'b01, 1'b0);

        wd[0] = 32'h12345678; ws[0] = 4'hF;
        axi_write(4'h9, 64'h84, 8'd0, 2'b01);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 5); ws[i] = 4'hF; end
        axi_write(4'hA, 64'h80, 8'd2, 2'b00);
        push(32'h7, 1'b0);
        push(32'h12345678, 1'b1);
        axi_read(4'hB, 64'h80, 8'd1, 2'b01, 1'b0);

        // Burst running off the top of the array lands back at word 0.
        wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB0B0B0B0; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(4'hC, 64'hFFC, 8'd1, 2'b01);
        push(32'hB0B0B0B0, 1'b1);
        axi_read(4'hD, 64'h000, 8'd0, 2'b01, 1'b0);
        push(32'hA0A0A0A0, 1'b0);
        push(32'hB0B0B0B0, 1'b1);
        axi_read(4'hE, 64'hFFC, 8'd1, 2'b01, 1'b0);

        // Reset in the middle of a write burst: no B, earlier beats kept.
        aw_send(4'h4, 64'h300, 8'd3, 2'b01);
        w_send(32'hCAFE0001, 4'hF, 1'b0);
        w_send(32'hCAFE0002, 4'hF, 1'b0);
        arst_ni = 1'b0;
        #1;
        check("midrst_b_valid", 64'(b_valid_o), 64'h0);
        check("midrst_w_ready", 64'(w_ready_o), 64'h0);
        check("midrst_aw_ready", 64'(aw_ready_o), 64'h1);
        step();
        arst_ni = 1'b1;
        step();
        check("postrst_b_valid", 64'(b_valid_o), 64'h0);
        push(32'hCAFE0001, 1'b0);
        push(32'hCAFE0002, 1'b1);
        axi_read(4'hF, 64'h300, 8'd1, 2'b01, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
